// File: rtl/bram_byte_port.sv
// rtl/bram_byte_port.sv - byte-addressed read/write store tiled over NUM_BANKS 256x16 BRAM blocks.
// Each bank below models one SB_RAM40_4K in 256x16 mode (registered read, active-low write mask).
module bram_byte_port #(
  parameter int          ADDR_W         = 10,
  parameter bit          CLEAR_ON_RESET = 1'b1,
  parameter logic [15:0] CLEAR_VALUE    = 16'h0000
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [7:0]        req_wdata,
  output logic              rsp_valid,
  output logic [7:0]        rsp_data,
  output logic              init_done
);

  localparam int NUM_BANKS = 1 << (ADDR_W - 9);
  localparam int BANK_W    = (ADDR_W > 9) ? (ADDR_W - 9) : 1;

  typedef enum logic {ST_CLEAR, ST_RUN} state_t;

  state_t              r_state;
  state_t              w_state_nxt;
  logic [7:0]          r_clr_cnt;
  logic [7:0]          w_clr_cnt_nxt;
  logic                r_ready;
  logic                r_init_done;

  logic [BANK_W-1:0]   w_bank;
  logic [7:0]          w_row;
  logic                w_lane;
  logic                w_accept;

  logic [NUM_BANKS-1:0] w_we;
  logic [7:0]          w_waddr;
  logic [15:0]         w_wdata;
  logic [15:0]         w_mask;
  logic                w_re;
  logic [15:0]         w_bank_q [NUM_BANKS];

  logic                r_p1_valid;
  logic [BANK_W-1:0]   r_p1_bank;
  logic                r_p1_lane;
  logic                r_p2_valid;
  logic                r_p2_lane;
  logic [15:0]         r_word;
  logic                r_rsp_valid;
  logic [7:0]          r_rsp_data;

  generate
    if (ADDR_W > 9) begin : g_bank_sel
      assign w_bank = req_addr[ADDR_W-1:9];
    end else begin : g_single_bank
      assign w_bank = 1'b0;
    end
  endgenerate

  assign w_row    = req_addr[8:1];
  assign w_lane   = req_addr[0];
  assign w_accept = req_valid & r_ready;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state     <= CLEAR_ON_RESET ? ST_CLEAR : ST_RUN;
      r_clr_cnt   <= 8'h00;
      r_ready     <= 1'b0;
      r_init_done <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_clr_cnt   <= w_clr_cnt_nxt;
      r_ready     <= (w_state_nxt == ST_RUN);
      r_init_done <= (w_state_nxt == ST_RUN);
    end
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_clr_cnt_nxt = r_clr_cnt;
    if (r_state == ST_CLEAR) begin
      w_clr_cnt_nxt = r_clr_cnt + 8'd1;
      if (r_clr_cnt == 8'hFF) w_state_nxt = ST_RUN;
    end
  end

  // Clear writes the same row of every bank at once; normal writes hit one bank, one lane.
  always_comb begin
    w_we    = '0;
    w_waddr = w_row;
    w_wdata = {req_wdata, req_wdata};
    w_mask  = w_lane ? 16'h00FF : 16'hFF00;
    w_re    = 1'b0;
    if (r_state == ST_CLEAR) begin
      w_we    = '1;
      w_waddr = r_clr_cnt;
      w_wdata = CLEAR_VALUE;
      w_mask  = 16'h0000;
    end else if (w_accept) begin
      if (req_we) w_we[w_bank] = 1'b1;
      else        w_re         = 1'b1;
    end
  end

  generate
    for (genvar b = 0; b < NUM_BANKS; b++) begin : g_bank
      logic [15:0] r_mem [256];
      logic [15:0] r_q;
      always_ff @(posedge clk) begin
        if (w_we[b]) r_mem[w_waddr] <= (r_mem[w_waddr] & w_mask) | (w_wdata & ~w_mask);
        if (w_re)    r_q <= r_mem[w_row];
      end
      assign w_bank_q[b] = r_q;
    end
  endgenerate

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_p1_valid  <= 1'b0;
      r_p1_bank   <= '0;
      r_p1_lane   <= 1'b0;
      r_p2_valid  <= 1'b0;
      r_p2_lane   <= 1'b0;
      r_word      <= 16'h0000;
      r_rsp_valid <= 1'b0;
      r_rsp_data  <= 8'h00;
    end else begin
      r_p1_valid  <= w_re;
      r_p1_bank   <= w_bank;
      r_p1_lane   <= w_lane;
      r_p2_valid  <= r_p1_valid;
      r_p2_lane   <= r_p1_lane;
      if (r_p1_valid) r_word <= w_bank_q[r_p1_bank];
      r_rsp_valid <= r_p2_valid;
      if (r_p2_valid) r_rsp_data <= r_p2_lane ? r_word[15:8] : r_word[7:0];
    end
  end

  assign req_ready = r_ready;
  assign init_done = r_init_done;
  assign rsp_valid = r_rsp_valid;
  assign rsp_data  = r_rsp_data;

endmodule

// File: tb/tb_bram_byte_port.sv
// tb/tb_bram_byte_port.sv - directed table-driven bench for bram_byte_port (ADDR_W=10, clear on reset).
module tb_bram_byte_port;

  logic       clk = 1'b0;
  logic       reset;
  logic       req_valid;
  logic       req_ready;
  logic       req_we;
  logic [9:0] req_addr;
  logic [7:0] req_wdata;
  logic       rsp_valid;
  logic [7:0] rsp_data;
  logic       init_done;

  int checks = 0;
  int errors = 0;

  bram_byte_port #(
    .ADDR_W        (10),
    .CLEAR_ON_RESET(1'b1),
    .CLEAR_VALUE   (16'h0000)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .req_valid(req_valid),
    .req_ready(req_ready),
    .req_we   (req_we),
    .req_addr (req_addr),
    .req_wdata(req_wdata),
    .rsp_valid(rsp_valid),
    .rsp_data (rsp_data),
    .init_done(init_done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       v;
    logic       we;
    logic [9:0] addr;
    logic [7:0] wd;
    logic       ev;
    logic [7:0] ed;
  } vec_t;

  vec_t tbl [64];
  int   n_vec = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // A read issued in row i is expected to show its response when row i+3 is sampled.
  function automatic void add(input logic v, input logic we, input logic [9:0] a,
                              input logic [7:0] wd, input logic [7:0] ed);
    tbl[n_vec].v    = v;
    tbl[n_vec].we   = we;
    tbl[n_vec].addr = a;
    tbl[n_vec].wd   = wd;
    if (v && !we) begin
      tbl[n_vec+3].ev = 1'b1;
      tbl[n_vec+3].ed = ed;
    end
    n_vec++;
  endfunction

  task automatic wait_clear(input string name);
    int cyc = 0;
    bit done = 1'b0;
    bit spurious = 1'b0;
    while (cyc < 1000 && !done) begin
      @(negedge clk);
      cyc++;
      if (rsp_valid) spurious = 1'b1;
      if (req_ready) done = 1'b1;
    end
    check({name, "_clear_cycles"}, cyc, 256);
    check({name, "_init_done"}, {31'b0, init_done}, 1);
    check({name, "_no_rsp_in_clear"}, {31'b0, spurious}, 0);
  endtask

  initial begin
    for (int i = 0; i < 64; i++)
      tbl[i] = '{v: 1'b0, we: 1'b0, addr: 10'h0, wd: 8'h0, ev: 1'b0, ed: 8'h0};

    add(1, 0, 10'h000, 8'h00, 8'h00);
    add(1, 0, 10'h1FF, 8'h00, 8'h00);
    add(1, 0, 10'h3FF, 8'h00, 8'h00);
    add(1, 1, 10'h013, 8'hA5, 8'h00);
    add(1, 0, 10'h013, 8'h00, 8'hA5);
    add(1, 0, 10'h012, 8'h00, 8'h00);
    add(1, 1, 10'h005, 8'h11, 8'h00);
    add(1, 1, 10'h205, 8'h22, 8'h00);
    add(1, 0, 10'h005, 8'h00, 8'h11);
    add(1, 0, 10'h205, 8'h00, 8'h22);
    add(0, 0, 10'h000, 8'h00, 8'h00);
    add(1, 1, 10'h300, 8'h33, 8'h00);
    add(1, 0, 10'h300, 8'h00, 8'h33);
    add(1, 1, 10'h301, 8'h44, 8'h00);
    add(1, 0, 10'h301, 8'h00, 8'h44);
    for (int n = 0; n < 16; n++) add(1, 1, 10'h040 + 10'(n), 8'h40 + 8'(n), 8'h00);
    for (int n = 0; n < 16; n++) add(1, 0, 10'h040 + 10'(n), 8'h00, 8'h40 + 8'(n));
    for (int n = 0; n < 3; n++)  add(0, 0, 10'h000, 8'h00, 8'h00);

    reset     = 1'b0;
    req_valid = 1'b0;
    req_we    = 1'b0;
    req_addr  = 10'h000;
    req_wdata = 8'h00;
    repeat (3) @(negedge clk);
    check("rst_req_ready", {31'b0, req_ready}, 0);
    check("rst_rsp_valid", {31'b0, rsp_valid}, 0);
    check("rst_rsp_data", {24'b0, rsp_data}, 0);
    check("rst_init_done", {31'b0, init_done}, 0);
    reset = 1'b1;
    wait_clear("boot");

    for (int i = 0; i < n_vec; i++) begin
      check($sformatf("row%0d_rsp_valid", i), {31'b0, rsp_valid}, {31'b0, tbl[i].ev});
      if (tbl[i].ev) check($sformatf("row%0d_rsp_data", i), {24'b0, rsp_data}, {24'b0, tbl[i].ed});
      check($sformatf("row%0d_req_ready", i), {31'b0, req_ready}, 1);
      req_valid = tbl[i].v;
      req_we    = tbl[i].we;
      req_addr  = tbl[i].addr;
      req_wdata = tbl[i].wd;
      @(negedge clk);
    end
    req_valid = 1'b0;
    check("hold_rsp_valid", {31'b0, rsp_valid}, 0);
    check("hold_rsp_data", {24'b0, rsp_data}, 32'h4F);

    req_valid = 1'b1;
    req_we    = 1'b0;
    req_addr  = 10'h040;
    @(negedge clk);
    req_addr  = 10'h041;
    @(negedge clk);
    req_valid = 1'b0;
    reset     = 1'b0;
    #1;
    check("midrst_rsp_valid", {31'b0, rsp_valid}, 0);
    check("midrst_rsp_data", {24'b0, rsp_data}, 0);
    check("midrst_req_ready", {31'b0, req_ready}, 0);
    check("midrst_init_done", {31'b0, init_done}, 0);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check($sformatf("midrst_drop%0d", k), {31'b0, rsp_valid}, 0);
    end
    reset = 1'b1;
    wait_clear("restart");

    req_valid = 1'b1;
    req_we    = 1'b0;
    req_addr  = 10'h040;
    @(negedge clk);
    req_valid = 1'b0;
    @(negedge clk);
    check("post_clear_early", {31'b0, rsp_valid}, 0);
    @(negedge clk);
    check("post_clear_rsp_valid", {31'b0, rsp_valid}, 1);
    check("post_clear_rsp_data", {24'b0, rsp_data}, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
